// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and PC-select encodings.
// Latency: n/a (types, constants and a pure helper only).
// Backpressure: n/a.
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ     = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  // PC-select codes driven by execute; 2'b11 behaves like sequential.
  localparam logic [1:0] PCSRC_SEQ    = 2'b00;
  localparam logic [1:0] PCSRC_TARGET = 2'b01;
  localparam logic [1:0] PCSRC_JALR   = 2'b10;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // True when execute is steering fetch away from the sequential path.
  function automatic logic is_redirect(input logic [1:0] pcsrc);
    case (pcsrc)
      PCSRC_TARGET, PCSRC_JALR: return 1'b1;
      PCSRC_SEQ:                return 1'b0;
      default:                  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry {instr, pc, valid} holding register parking a response while decode is stalled.
// Latency: a load is visible on the outputs after one edge.
// Backpressure: none internally; the owner stops issuing fetches while the entry is valid.
module fetch_skid_buffer
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             drain,
  input  logic             clear,
  input  logic [31:0]      load_instr,
  input  logic [WIDTH-1:0] load_pc,
  output logic [31:0]      instr,
  output logic [WIDTH-1:0] pc,
  output logic             valid
);

  // Clear (redirect) wins over load, load wins over drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
      pc    <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= load_instr;
      pc    <= load_pc;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns pcf, issues one imem request at a time, fills the IF/ID register.
// Latency: request accepted at edge t, response in cycle t+k -> instrd valid after edge t+k.
// Backpressure: holds request until imem_req_ready; a stalled decode parks one response in the skid.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       pcsrce,
  input  logic [WIDTH-1:0] pctargete,
  input  logic [WIDTH-1:0] aluresulte,
  input  logic             stall_lu,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_rsp_valid,
  input  logic [31:0]      imem_rsp_data,
  output logic [31:0]      instrd,
  output logic [WIDTH-1:0] pcd,
  output logic             validd,
  output logic             flushd,
  output logic             flushe
);

  localparam logic [WIDTH-1:0] PC_STEP  = WIDTH'(4);
  localparam logic [WIDTH-1:0] LSB_MASK = ~WIDTH'(1);

  fetch_state_t     state_q;
  fetch_state_t     state_d;
  logic [WIDTH-1:0] pcf;
  logic [WIDTH-1:0] req_pc;
  logic [WIDTH-1:0] redir_pc;
  logic             redir;
  logic             accept;
  logic             deliver;

  logic [31:0]      skid_instr;
  logic [WIDTH-1:0] skid_pc;
  logic             skid_valid;
  logic             skid_load;
  logic             skid_drain;

  assign redir     = is_redirect(pcsrce);
  assign redir_pc  = (pcsrce == PCSRC_TARGET) ? pctargete : (aluresulte & LSB_MASK);
  assign flushd    = redir;
  assign flushe    = redir;
  assign imem_addr = pcf;
  assign accept    = imem_req_valid & imem_req_ready;

  // A response delivered while decode is stalled is parked; it leaves when the stall drops.
  assign skid_load  = deliver & stall_lu;
  assign skid_drain = !redir & !stall_lu & skid_valid;

  fetch_skid_buffer #(
    .WIDTH(WIDTH)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .load       (skid_load),
    .drain      (skid_drain),
    .clear      (redir),
    .load_instr (imem_rsp_data),
    .load_pc    (req_pc),
    .instr      (skid_instr),
    .pc         (skid_pc),
    .valid      (skid_valid)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= REQ;
    else     state_q <= state_d;
  end

  // Next state, request valid and response delivery; a redirect turns any in-flight fetch stale.
  always_comb begin
    state_d        = state_q;
    imem_req_valid = 1'b0;
    deliver        = 1'b0;
    case (state_q)
      REQ: begin
        imem_req_valid = !skid_valid && !rst;
        if (imem_req_valid && imem_req_ready) state_d = redir ? DISCARD : WAIT;
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          deliver = !redir;
          state_d = REQ;
        end else if (redir) begin
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (imem_rsp_valid) state_d = REQ;
      end
      default: state_d = REQ;
    endcase
  end

  // PC register: redirect beats the sequential step; req_pc tags the outstanding response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcf    <= RESET_PC;
      req_pc <= '0;
    end else begin
      if (redir)       pcf <= redir_pc;
      else if (accept) pcf <= pcf + PC_STEP;
      if (accept) req_pc <= pcf;
    end
  end

  // IF/ID register: redirect kills, stall holds, otherwise skid first, then fresh response, else bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      validd <= 1'b0;
      instrd <= '0;
      pcd    <= '0;
    end else if (redir) begin
      validd <= 1'b0;
    end else if (!stall_lu) begin
      if (skid_valid) begin
        validd <= 1'b1;
        instrd <= skid_instr;
        pcd    <= skid_pc;
      end else if (deliver) begin
        validd <= 1'b1;
        instrd <= imem_rsp_data;
        pcd    <= req_pc;
      end else begin
        validd <= 1'b0;
      end
    end
  end

endmodule
